// File: rtl/vend_dispense_sequencer.sv
// ---------------------------------------------------------------------------
// vend_dispense_sequencer
//
// Purpose: carries out the physical part of a vend once the vending
// controller has settled a purchase. One command (product slot + change owed
// in nickels) drives the slot's motor, waits for the drop sensor with a
// timeout, then pulses the coin-return solenoid once per nickel and reports
// completion (done) together with a fault flag.
//
// Optional feature macro: VEND_RETRY_EN
//   defined   -> the first drop-sensor timeout re-runs the motor once;
//                fault is raised only if the retry also times out.
//   undefined -> the first timeout raises fault directly.
//
// Ports:
//   clk          in   system clock, rising edge
//   clr_n        in   asynchronous active-low reset
//   cmd_valid    in   command offered
//   cmd_ready    out  high only in IDLE; accept = cmd_valid & cmd_ready
//   cmd_prod     in   [1:0] product slot 0..3
//   cmd_change   in   [2:0] change owed in nickels (5..7 clamped to 4)
//   drop_sense   in   synchronised product-drop sensor, active-high
//   motor        out  [3:0] one-hot motor drive, bit = latched slot
//   coin_pulse   out  coin-return solenoid drive
//   change_left  out  [2:0] nickels still to be returned
//   busy         out  high in every state except IDLE
//   done         out  one-cycle pulse at the end of each command
//   fault        out  drop never seen; valid with done, held until next accept
// ---------------------------------------------------------------------------
module vend_dispense_sequencer #(
  parameter int MOTOR_CYCLES  = 8,
  parameter int SENSE_TIMEOUT = 64,
  parameter int PULSE_CYCLES  = 4,
  parameter int GAP_CYCLES    = 4
) (
  input  logic       clk,
  input  logic       clr_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_prod,
  input  logic [2:0] cmd_change,
  input  logic       drop_sense,
  output logic [3:0] motor,
  output logic       coin_pulse,
  output logic [2:0] change_left,
  output logic       busy,
  output logic       done,
  output logic       fault
);

  localparam int MAX_A = (MOTOR_CYCLES > SENSE_TIMEOUT) ? MOTOR_CYCLES : SENSE_TIMEOUT;
  localparam int MAX_B = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W = $clog2(MAX_C + 1);

  localparam logic [CNT_W-1:0] MOTOR_LAST = CNT_W'(MOTOR_CYCLES - 1);
  localparam logic [CNT_W-1:0] SENSE_LAST = CNT_W'(SENSE_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MOTOR,
    S_SENSE,
    S_PAY_HI,
    S_PAY_LO,
    S_DONE
  } state_t;

  function automatic logic [2:0] clamp_change(input logic [2:0] c);
    return (c > 3'd4) ? 3'd4 : c;
  endfunction

  state_t           r_state, w_state_nx;
  logic [CNT_W-1:0] r_cnt, w_cnt_nx;
  logic [1:0]       r_slot, w_slot_nx;
  logic [2:0]       r_change, w_change_nx;
  logic             r_drop, w_drop_nx;
  logic             r_fault, w_fault_nx;
`ifdef VEND_RETRY_EN
  logic             r_retry, w_retry_nx;
`endif

  logic [3:0]       r_motor;
  logic             r_coin;
  logic             r_busy;
  logic             r_done;
  logic             r_ready;

  state_t           w_pay_dest;

  // Where SENSE goes once it is finished (drop or final timeout).
  assign w_pay_dest = (r_change != 3'd0) ? S_PAY_HI : S_DONE;

  always_comb begin
    w_state_nx  = r_state;
    w_cnt_nx    = r_cnt;
    w_slot_nx   = r_slot;
    w_change_nx = r_change;
    w_drop_nx   = r_drop;
    w_fault_nx  = r_fault;
`ifdef VEND_RETRY_EN
    w_retry_nx  = r_retry;
`endif
    case (r_state)
      S_IDLE: begin
        if (cmd_valid) begin
          w_state_nx  = S_MOTOR;
          w_cnt_nx    = '0;
          w_slot_nx   = cmd_prod;
          w_change_nx = clamp_change(cmd_change);
          w_drop_nx   = 1'b0;
          w_fault_nx  = 1'b0;
`ifdef VEND_RETRY_EN
          w_retry_nx  = 1'b0;
`endif
        end
      end
      S_MOTOR: begin
        // A product can fall while the motor is still turning.
        if (drop_sense) w_drop_nx = 1'b1;
        if (r_cnt == MOTOR_LAST) begin
          w_state_nx = S_SENSE;
          w_cnt_nx   = '0;
        end else begin
          w_cnt_nx = r_cnt + CNT_W'(1);
        end
      end
      S_SENSE: begin
        // Drop is checked before expiry so a coincident drop wins.
        if (r_drop || drop_sense) begin
          w_state_nx = w_pay_dest;
          w_cnt_nx   = '0;
        end else if (r_cnt == SENSE_LAST) begin
          w_cnt_nx = '0;
`ifdef VEND_RETRY_EN
          if (!r_retry) begin
            w_state_nx = S_MOTOR;
            w_retry_nx = 1'b1;
            w_drop_nx  = 1'b0;
          end else begin
            w_fault_nx = 1'b1;
            w_state_nx = w_pay_dest;
          end
`else
          w_fault_nx = 1'b1;
          w_state_nx = w_pay_dest;
`endif
        end else begin
          w_cnt_nx = r_cnt + CNT_W'(1);
        end
      end
      S_PAY_HI: begin
        if (r_cnt == PULSE_LAST) begin
          w_state_nx  = S_PAY_LO;
          w_cnt_nx    = '0;
          w_change_nx = r_change - 3'd1;
        end else begin
          w_cnt_nx = r_cnt + CNT_W'(1);
        end
      end
      S_PAY_LO: begin
        // The gap after the last nickel is always served before DONE.
        if (r_cnt == GAP_LAST) begin
          w_state_nx = (r_change != 3'd0) ? S_PAY_HI : S_DONE;
          w_cnt_nx   = '0;
        end else begin
          w_cnt_nx = r_cnt + CNT_W'(1);
        end
      end
      S_DONE: begin
        w_state_nx = S_IDLE;
      end
      default: begin
        w_state_nx = S_IDLE;
      end
    endcase
  end

  // Control state and registered outputs; outputs are decoded from the next
  // state so they line up with the state they describe.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_change <= 3'd0;
      r_drop   <= 1'b0;
      r_fault  <= 1'b0;
`ifdef VEND_RETRY_EN
      r_retry  <= 1'b0;
`endif
      r_motor  <= 4'b0000;
      r_coin   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_ready  <= 1'b1;
    end else begin
      r_state  <= w_state_nx;
      r_cnt    <= w_cnt_nx;
      r_change <= w_change_nx;
      r_drop   <= w_drop_nx;
      r_fault  <= w_fault_nx;
`ifdef VEND_RETRY_EN
      r_retry  <= w_retry_nx;
`endif
      r_motor  <= (w_state_nx == S_MOTOR) ? (4'b0001 << w_slot_nx) : 4'b0000;
      r_coin   <= (w_state_nx == S_PAY_HI);
      r_busy   <= (w_state_nx != S_IDLE);
      r_done   <= (w_state_nx == S_DONE);
      r_ready  <= (w_state_nx == S_IDLE);
    end
  end

  // Slot is pure data: only meaningful while motor is decoded from MOTOR.
  always_ff @(posedge clk) begin
    r_slot <= w_slot_nx;
  end

  assign cmd_ready   = r_ready;
  assign motor       = r_motor;
  assign coin_pulse  = r_coin;
  assign change_left = r_change;
  assign busy        = r_busy;
  assign done        = r_done;
  assign fault       = r_fault;

endmodule

// File: tb/tb_vend_dispense_sequencer.sv
module tb_vend_dispense_sequencer;

  localparam int MOT = 8;
  localparam int TO  = 64;
  localparam int PUL = 4;
  localparam int GAP = 4;

  logic       clk = 1'b0;
  logic       clr_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd_prod = 2'd0;
  logic [2:0] cmd_change = 3'd0;
  logic       drop_sense = 1'b0;
  logic       cmd_ready;
  logic [3:0] motor;
  logic       coin_pulse;
  logic [2:0] change_left;
  logic       busy;
  logic       done;
  logic       fault;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  vend_dispense_sequencer #(
    .MOTOR_CYCLES (MOT),
    .SENSE_TIMEOUT(TO),
    .PULSE_CYCLES (PUL),
    .GAP_CYCLES   (GAP)
  ) dut (
    .clk        (clk),
    .clr_n      (clr_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_prod   (cmd_prod),
    .cmd_change (cmd_change),
    .drop_sense (drop_sense),
    .motor      (motor),
    .coin_pulse (coin_pulse),
    .change_left(change_left),
    .busy       (busy),
    .done       (done),
    .fault      (fault)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         done_k;
    int         sense_end;
    int         mot2;
    logic       flt;
    int         n;
    logic [3:0] oh;
  } exp_t;

  exp_t q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Monitor: k is the cycle offset from the accept edge (k=1 is the first
  // cycle after the accept).
  int   acc_cyc = 0;
  int   n_acc = 0;
  int   last_done = -100;
  int   acc_gap = 0;
  int   pulses = 0;
  logic in_cmd = 1'b0;
  logic prev_coin = 1'b0;

  always @(negedge clk) begin
    int         k;
    logic [3:0] m_exp;
    logic       c_exp;
    if (!clr_n) begin
      in_cmd = 1'b0;
      q.delete();
    end else begin
      k = cyc - acc_cyc;
      if (in_cmd && q.size() > 0) begin
        m_exp = ((k >= 1 && k <= MOT) ||
                 (q[0].mot2 > 0 && k >= q[0].mot2 && k < q[0].mot2 + MOT)) ? q[0].oh : 4'b0000;
        c_exp = (k > q[0].sense_end && k < q[0].done_k &&
                 ((k - q[0].sense_end - 1) % (PUL + GAP)) < PUL);
        chk("motor", motor, m_exp);
        chk("coin_pulse", coin_pulse, c_exp);
        chk("busy", busy, 1);
        chk("cmd_ready", cmd_ready, 0);
        chk("done", done, (k == q[0].done_k));
        if (k == 1) chk("fault_clr", fault, 0);
        if (coin_pulse && !prev_coin) begin
          chk("change_left", change_left, q[0].n - pulses);
          pulses++;
        end
        if (done) begin
          chk("fault", fault, q[0].flt);
          chk("n_pulses", pulses, q[0].n);
          chk("change_end", change_left, 0);
          last_done = cyc;
          void'(q.pop_front());
          in_cmd = 1'b0;
        end
      end
      if (cmd_valid && cmd_ready) begin
        acc_gap = cyc - last_done;
        acc_cyc = cyc;
        n_acc++;
        in_cmd = 1'b1;
        pulses = 0;
      end
    end
    prev_coin = coin_pulse;
  end

  // Drive a command; push its expectation; optionally pulse drop_sense at
  // offset dk (0 = never), keep cmd_valid high (hold) and wait for done.
  task automatic issue(input logic [1:0] p, input logic [2:0] c, input int dk,
                       input bit hold, input bit wait_done);
    exp_t e;
    int   nn;
    int   se;
    int   a0;
    int   t;
    nn = (c > 3'd4) ? 4 : int'(c);
    e.mot2 = 0;
    e.flt  = 1'b0;
    if (dk >= 1 && dk <= MOT) se = MOT + 1;
    else if (dk > MOT && dk <= MOT + TO) se = dk;
    else begin
      e.flt = 1'b1;
`ifdef VEND_RETRY_EN
      se = 2 * (MOT + TO);
      e.mot2 = MOT + TO + 1;
`else
      se = MOT + TO;
`endif
    end
    e.sense_end = se;
    e.done_k = se + 1 + (PUL + GAP) * nn;
    e.n = nn;
    e.oh = 4'b0001 << p;
    q.push_back(e);
    a0 = n_acc;
    cmd_prod = p;
    cmd_change = c;
    cmd_valid = 1'b1;
    t = 0;
    while (n_acc == a0 && t < 400) begin
      @(posedge clk); #1;
      t++;
    end
    if (n_acc == a0) chk("accept_timeout", 0, 1);
    if (!hold) cmd_valid = 1'b0;
    if (dk > 0) begin
      t = 0;
      while ((cyc - acc_cyc) < dk && t < 400) begin
        @(posedge clk); #1;
        t++;
      end
      drop_sense = 1'b1;
      @(posedge clk); #1;
      drop_sense = 1'b0;
    end
    if (wait_done) begin
      t = 0;
      while (q.size() > 0 && t < 400) begin
        @(posedge clk); #1;
        t++;
      end
      chk("stall", q.size(), 0);
    end
  endtask

  initial begin
    int a_before;
    int t;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_motor", motor, 0);
    chk("rst_coin", coin_pulse, 0);
    chk("rst_change", change_left, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_fault", fault, 0);
    clr_n = 1'b1;
    @(negedge clk);
    chk("rdy_after_rst", cmd_ready, 1);
    @(posedge clk); #1;

    // prod=2, change=2, drop at offset 4: done at 26.
    issue(2'd2, 3'd2, 4, 1'b0, 1'b1);
    // prod=0, change=0, drop during SENSE at 12: done at 13.
    issue(2'd0, 3'd0, 12, 1'b0, 1'b1);
    // change=7 clamps to 4.
    issue(2'd3, 3'd7, 2, 1'b0, 1'b1);
    // No drop at all, change=1: fault.
    issue(2'd1, 3'd1, 0, 1'b0, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    chk("fault_held", fault, 1);
    chk("idle_busy", busy, 0);

    // cmd_valid held across two commands; slot changes mid-command.
    a_before = n_acc;
    issue(2'd1, 3'd1, 3, 1'b1, 1'b0);
    issue(2'd2, 3'd0, 10, 1'b1, 1'b1);
    chk("gap_after_done", acc_gap, 1);
    chk("accepts", n_acc - a_before, 2);
    cmd_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("no_extra_accept", n_acc - a_before, 2);

    // Reset while paying change.
    issue(2'd1, 3'd3, 2, 1'b0, 1'b0);
    t = 0;
    while (!coin_pulse && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    chk("reached_pay", coin_pulse, 1);
    #1;
    clr_n = 1'b0;
    #1;
    chk("rst_mid_coin", coin_pulse, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_change", change_left, 0);
    chk("rst_mid_motor", motor, 0);
    @(posedge clk); #1;
    clr_n = 1'b1;
    @(negedge clk);
    chk("rst_mid_ready", cmd_ready, 1);
    @(posedge clk); #1;

    // A short command after reset still works.
    issue(2'd3, 3'd1, 5, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got %0d expected %0d", cyc, 0);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/vend_dispense_sequencer.md
# vend_dispense_sequencer

Sequences the physical vend for the vending machine. After the vending controller settles a purchase, it hands this block one command: a product slot and the change owed in nickels. The block drives the slot's dispense motor and waits for the drop sensor, with a timeout. It then pulses the coin-return solenoid once per nickel and reports completion or fault. It sits between the vending controller and the board's motor, sensor and solenoid pins.

## Interface
- MOTOR_CYCLES, 8: cycles the selected motor output is held high per attempt (≥1).
- SENSE_TIMEOUT, 64: maximum cycles spent waiting for drop_sense after the motor phase (≥1).
- PULSE_CYCLES, 4: coin_pulse high time per nickel (≥1).
- GAP_CYCLES, 4: coin_pulse low time after each nickel (≥1).
- clk  in  1  system clock; all state changes on its rising edge.
- clr_n  in  1  reset, asynchronous, active-low.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  high only in IDLE; a command is accepted on a rising edge with cmd_valid & cmd_ready.
- cmd_prod  in  2  product slot 0..3 (slot 0 = 15c, slot 1 = 20c, slot 2 = 25c, slot 3 = 30c).
- cmd_change  in  3  change owed in nickels; values 5..7 are clamped to 4.
- drop_sense  in  1  product-drop sensor, already synchronised, active-high.
- motor  out  4  one-hot motor drive; bit = cmd_prod.
- coin_pulse  out  1  coin-return solenoid drive.
- change_left  out  3  nickels still to be returned.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at the end of each command.
- fault  out  1  valid with done; held until the next accepted command.

## Operation
- States: IDLE, MOTOR, SENSE, PAY_HI, PAY_LO, DONE. A cycle counter is shared by all timed states.
- IDLE → MOTOR on accept:
  - latch the slot and the clamped change;
  - clear fault, the drop latch and the retry flag.
- MOTOR: motor[slot] high for MOTOR_CYCLES cycles, then → SENSE.
  - drop_sense seen during MOTOR sets the drop latch.
- SENSE: motor low.
  - Leave the first cycle the drop latch is set or drop_sense is high.
  - Destination: PAY_HI if change_left≠0, else DONE.
  - If SENSE_TIMEOUT cycles elapse with no drop: set fault, then proceed exactly as for a drop (change is still paid).
- PAY_HI: coin_pulse high for PULSE_CYCLES. On exit, change_left decrements by 1, then → PAY_LO.
- PAY_LO: coin_pulse low for GAP_CYCLES, then → PAY_HI if change_left≠0, else DONE.
- DONE: done=1 for one cycle; fault is valid in that cycle. → IDLE.
- cmd_valid outside IDLE is ignored; there is no queueing.
- Simultaneous drop_sense and timeout expiry in the same SENSE cycle counts as a drop, so fault stays 0.
- Reset mid-operation: every output drops immediately. motor and coin_pulse never stay asserted through reset.

## Timing
- Reset values: motor=0, coin_pulse=0, change_left=0, busy=0, done=0, fault=0. cmd_ready=1 once reset is released.
- Accept edge T: busy and motor high from T+1 through T+MOTOR_CYCLES.
- If the drop was latched during MOTOR, SENSE lasts exactly one cycle.
- Each nickel costs PULSE_CYCLES+GAP_CYCLES cycles, and the final gap is included.
- Default parameters, drop seen during MOTOR, change=n:
  - done at T+10+8n;
  - cmd_ready high again at T+11+8n.
- Outputs are registered; none is combinational from inputs.

## Configuration
- VEND_RETRY_EN defined: the first SENSE timeout returns to MOTOR for one retry.
  - Counter and drop latch are cleared.
  - fault is set only if the retry's SENSE also times out.
- Undefined: the first timeout sets fault; there is no retry path.

## Test plan
- Reset with clr_n=0 during PAY_HI → coin_pulse, busy and change_left all 0 immediately. After release, cmd_ready=1.
- Default parameters: prod=2, change=2, drop_sense pulsed at T+4:
  - motor=4'b0100 from T+1 to T+8;
  - coin_pulse high T+10..13 and T+18..21;
  - done at T+26, fault=0.
- prod=0, change=0, drop_sense at T+12 → done at T+13, no coin_pulse.
- change=7 → clamped to 4: exactly four coin pulses, change_left goes 4,3,2,1,0.
- drop_sense never asserted, change=1:
  - without VEND_RETRY_EN: SENSE runs T+9..T+72; coin_pulse T+73..76; done with fault=1 at T+81;
  - with VEND_RETRY_EN: a second motor burst follows, then fault.
- cmd_valid held high throughout a command → exactly one accept. The next accept occurs the cycle after done.
